// File: rtl/v_pkg.sv
`default_nettype none
// ============================================================================
// Package     : v_pkg
// Description : Shared types for the per-product state table.
//               addr_t - state table RAM address.
// Revision    : 1.0 - initial release
// ============================================================================
package v_pkg;

    localparam int ADDR_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage : v_pkg
`default_nettype wire

// File: rtl/v_state_rd_arb_if.sv
`default_nettype none
// ============================================================================
// Interface   : v_state_rd_arb_if
// Description : Bundles the query-side, update-side and RAM-side signals of
//               the state table read-port arbiter.
//               slave  - arbiter view (i_* in, o_* out)
//               master - requester/RAM view (i_* out, o_* in)
//   i_qry_ren / i_qry_raddr        query read request and address
//   o_qry_block                    query source must hold off while high
//   o_qry_rdata_vld                read data belongs to last-cycle query
//   i_upd_req / i_upd_raddr        update read request and address (held)
//   o_upd_gnt                      update request consumed this cycle
//   o_upd_rdata_vld                read data belongs to last-cycle update
//   o_state_ren / o_state_raddr    RAM read command
//   o_err_proto                    query asserted while blocked (pulse)
// Revision    : 1.0 - initial release
// ============================================================================
interface v_state_rd_arb_if;
    import v_pkg::*;

    logic  i_qry_ren;
    addr_t i_qry_raddr;
    logic  o_qry_block;
    logic  o_qry_rdata_vld;
    logic  i_upd_req;
    addr_t i_upd_raddr;
    logic  o_upd_gnt;
    logic  o_upd_rdata_vld;
    logic  o_state_ren;
    addr_t o_state_raddr;
    logic  o_err_proto;

    modport slave (
        input  i_qry_ren, i_qry_raddr, i_upd_req, i_upd_raddr,
        output o_qry_block, o_qry_rdata_vld, o_upd_gnt, o_upd_rdata_vld,
               o_state_ren, o_state_raddr, o_err_proto
    );

    modport master (
        output i_qry_ren, i_qry_raddr, i_upd_req, i_upd_raddr,
        input  o_qry_block, o_qry_rdata_vld, o_upd_gnt, o_upd_rdata_vld,
               o_state_ren, o_state_raddr, o_err_proto
    );

endinterface : v_state_rd_arb_if
`default_nettype wire

// File: rtl/v_state_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : v_state_rd_arb
// Description : Arbiter for the single read port of the per-product state
//               table RAM. The query pipeline has default priority and is
//               never stalled; the update pipeline is granted whenever the
//               port is free. Read data is broadcast, with registered
//               per-requester return-valid strobes.
//
//               Optional anti-starvation (macro V_STATE_RD_ARB_STARVE_EN):
//               after STARVE_N consecutive denied update cycles the query
//               source is blocked (o_qry_block) until the update is served.
//               Without the macro: strict query priority, o_qry_block and
//               o_err_proto tied 0, STARVE_N unused.
//
// Parameters  : STARVE_N  denied update cycles before blocking (2..255)
// Ports       : clk       clock
//               rst       synchronous active-high reset
//               bus       v_state_rd_arb_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module v_state_rd_arb #(
    parameter int STARVE_N = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    v_state_rd_arb_if.slave     bus
);

    if (STARVE_N < 2 || STARVE_N > 255) begin : g_starve_n_range
        $error("v_state_rd_arb: STARVE_N must be within 2..255");
    end

    // ------------------------------------------------------------------
    // Arbitration. The query always wins when it asserts, even while
    // blocked, so the latency path is never broken; the block flag only
    // takes effect through a compliant query source staying quiet.
    // ------------------------------------------------------------------
    logic w_upd_gnt;

    assign w_upd_gnt          = !rst && bus.i_upd_req && !bus.i_qry_ren;
    assign bus.o_upd_gnt      = w_upd_gnt;
    assign bus.o_state_ren    = bus.i_qry_ren | w_upd_gnt;
    assign bus.o_state_raddr  = w_upd_gnt ? bus.i_upd_raddr : bus.i_qry_raddr;

    // ------------------------------------------------------------------
    // Return strobes: RAM data arrives one cycle after the read enable.
    // Requests issued during rst produce no strobe.
    // ------------------------------------------------------------------
    logic r_qry_rdata_vld;
    logic r_upd_rdata_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qry_rdata_vld <= 1'b0;
            r_upd_rdata_vld <= 1'b0;
        end else begin
            r_qry_rdata_vld <= bus.i_qry_ren;
            r_upd_rdata_vld <= w_upd_gnt;
        end
    end

    assign bus.o_qry_rdata_vld = r_qry_rdata_vld;
    assign bus.o_upd_rdata_vld = r_upd_rdata_vld;

`ifdef V_STATE_RD_ARB_STARVE_EN
    // ------------------------------------------------------------------
    // Anti-starvation: count consecutive denied update cycles and block
    // the query source on the STARVE_N-th denial.
    // ------------------------------------------------------------------
    localparam int                 c_CNT_W  = $clog2(STARVE_N + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_N);
    localparam logic [c_CNT_W-1:0] c_SET_AT  = c_CNT_W'(STARVE_N - 1);

    typedef enum logic [0:0] {
        S_OPEN  = 1'b0,
        S_BLOCK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_err_proto;
    logic                w_upd_denied;

    // A missing request and a grant both end the starvation episode.
    assign w_upd_denied = bus.i_upd_req && !w_upd_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_OPEN;
            r_cnt       <= '0;
            r_err_proto <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_proto <= bus.i_qry_ren && (r_state == S_BLOCK);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (!w_upd_denied) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_CNT_MAX) begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end

        case (r_state)
            S_OPEN: begin
                if (w_upd_denied && (r_cnt == c_SET_AT)) begin
                    w_state_nxt = S_BLOCK;
                end
            end
            S_BLOCK: begin
                // A violating query keeps the update denied, so the flag
                // holds until the update is actually served or withdrawn.
                if (!w_upd_denied) begin
                    w_state_nxt = S_OPEN;
                end
            end
            default: begin
                w_state_nxt = S_OPEN;
            end
        endcase
    end

    assign bus.o_qry_block = (r_state == S_BLOCK);
    assign bus.o_err_proto = r_err_proto;
`else
    assign bus.o_qry_block = 1'b0;
    assign bus.o_err_proto = 1'b0;
`endif

endmodule : v_state_rd_arb
`default_nettype wire

// File: tb/tb_v_state_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_v_state_rd_arb
// Description : Self-checking bench for v_state_rd_arb. A driver applies
//               per-cycle stimulus and pushes the expected outputs of that
//               cycle into a scoreboard queue; a monitor on the falling edge
//               pops and compares. Return strobes are also matched against
//               the cycle in which each request was issued.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_v_state_rd_arb;

    localparam int STARVE_N = 4;
`ifdef V_STATE_RD_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    typedef struct {
        bit           rst;
        bit           chk_reg;
        bit           gnt;
        bit           ren;
        v_pkg::addr_t raddr;
        bit           qv;
        bit           uv;
        bit           blk;
        bit           err;
    } exp_t;

    logic clk;
    logic rst;

    v_state_rd_arb_if u_if ();

    v_state_rd_arb #(
        .STARVE_N (STARVE_N)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   qret_q[$];
    int   uret_q[$];

    // Reference model state: what the registered outputs should show next.
    bit m_valid  = 1'b0;
    bit m_qv     = 1'b0;
    bit m_uv     = 1'b0;
    bit m_blk    = 1'b0;
    bit m_err    = 1'b0;
    int m_denied = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
        end
    endfunction

    // One clock of stimulus; g reports whether the update was granted.
    task automatic drive(input bit r, input bit qr, input v_pkg::addr_t qa,
                         input bit ur, input v_pkg::addr_t ua, output bit g);
        exp_t e;
        bit   denied;
        @(posedge clk);
        #1;
        cyc++;
        rst               = r;
        u_if.i_qry_ren    = qr;
        u_if.i_qry_raddr  = qa;
        u_if.i_upd_req    = ur;
        u_if.i_upd_raddr  = ua;

        e.rst     = r;
        e.chk_reg = m_valid;
        e.gnt     = !r && ur && !qr;
        e.ren     = qr || e.gnt;
        e.raddr   = e.gnt ? ua : qa;
        e.qv      = m_qv;
        e.uv      = m_uv;
        e.blk     = m_blk;
        e.err     = m_err;
        exp_q.push_back(e);
        g = e.gnt;

        if (!r && qr)    qret_q.push_back(cyc);
        if (e.gnt)       uret_q.push_back(cyc);

        if (r) begin
            m_qv = 0; m_uv = 0; m_blk = 0; m_err = 0; m_denied = 0;
            m_valid = 1'b1;
        end else begin
            m_qv  = qr;
            m_uv  = e.gnt;
            m_err = STARVE_EN && qr && m_blk;
            denied = ur && !e.gnt;
            if (STARVE_EN) begin
                if (!denied) begin
                    m_denied = 0;
                    m_blk    = 1'b0;
                end else begin
                    m_denied++;
                    if (m_denied >= STARVE_N) m_blk = 1'b1;
                end
            end
        end
    endtask

    // Monitor: compare every presented cycle away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("upd_gnt", u_if.o_upd_gnt, e.gnt);
            if (!e.rst) begin
                chk("state_ren", u_if.o_state_ren, e.ren);
                if (e.ren) chk("state_raddr", u_if.o_state_raddr, e.raddr);
            end
            if (e.chk_reg) begin
                chk("qry_rdata_vld", u_if.o_qry_rdata_vld, e.qv);
                chk("upd_rdata_vld", u_if.o_upd_rdata_vld, e.uv);
                chk("qry_block",     u_if.o_qry_block,     e.blk);
                chk("err_proto",     u_if.o_err_proto,     e.err);
            end
            if (u_if.o_qry_rdata_vld === 1'b1) begin
                while (qret_q.size() > 0 && qret_q[0] < cyc - 1) void'(qret_q.pop_front());
                if (qret_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL qry_ret cycle=%0d actual=strobe expected=no pending query", cyc);
                end else begin
                    chk("qry_ret_cycle", qret_q.pop_front(), cyc - 1);
                end
            end
            if (u_if.o_upd_rdata_vld === 1'b1) begin
                while (uret_q.size() > 0 && uret_q[0] < cyc - 1) void'(uret_q.pop_front());
                if (uret_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL upd_ret cycle=%0d actual=strobe expected=no pending grant", cyc);
                end else begin
                    chk("upd_ret_cycle", uret_q.pop_front(), cyc - 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           g;
        bit           pend;
        v_pkg::addr_t ua;
        rst              = 1'b1;
        u_if.i_qry_ren   = 1'b0;
        u_if.i_qry_raddr = '0;
        u_if.i_upd_req   = 1'b0;
        u_if.i_upd_raddr = '0;

        repeat (3) drive(1, 0, 8'h00, 0, 8'h00, g);
        repeat (2) drive(0, 0, 8'h00, 0, 8'h00, g);

        // Lone update is granted at once.
        drive(0, 0, 8'h00, 1, 8'h05, g);
        drive(0, 0, 8'h00, 0, 8'h00, g);

        // Simultaneous query and update: query first, update next free cycle.
        drive(0, 1, 8'h03, 1, 8'h07, g);
        drive(0, 0, 8'h00, 1, 8'h07, g);
        drive(0, 0, 8'h00, 0, 8'h00, g);

        // Back-to-back queries with an update held; compliant source.
        pend = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(0, !m_blk, 8'(8'h20 + i), pend, 8'h09, g);
            if (g) pend = 1'b0;
        end
        drive(0, 0, 8'h00, 0, 8'h00, g);

        // Same, but the query source ignores the block.
        for (int i = 0; i < 8; i++) drive(0, 1, 8'(8'h40 + i), 1, 8'h0A, g);
        drive(0, 0, 8'h00, 1, 8'h0A, g);
        drive(0, 0, 8'h00, 0, 8'h00, g);

        // Starve, then reset mid-operation.
        for (int i = 0; i < 5; i++) drive(0, 1, 8'h11, 1, 8'h0B, g);
        drive(1, 1, 8'h04, 1, 8'h06, g);
        drive(0, 0, 8'h00, 1, 8'h06, g);
        drive(0, 0, 8'h00, 0, 8'h00, g);

        // Randomised traffic.
        pend = 1'b0;
        ua   = '0;
        for (int i = 0; i < 1500; i++) begin
            bit r, qr, ur;
            r = ($urandom_range(0, 99) == 0);
            if (m_blk) qr = ($urandom_range(0, 9) == 0);
            else       qr = ($urandom_range(0, 9) < 8);
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                ua   = 8'($urandom);
            end else if (pend && $urandom_range(0, 49) == 0) begin
                pend = 1'b0;
            end
            ur = pend;
            drive(r, qr, 8'($urandom), ur, ua, g);
            if (g) pend = 1'b0;
        end

        repeat (2) drive(0, 0, 8'h00, 0, 8'h00, g);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_v_state_rd_arb
`default_nettype wire

// File: doc/v_state_rd_arb.md
# v_state_rd_arb

Arbiter for the single read port of the per-product state table RAM.
- Requesters: the query pipeline (latency-critical, one-cycle RAM read) and the update pipeline (stallable).
- Default priority: queries. Updates are granted whenever the port is idle.
- Optional anti-starvation: after a bounded number of denied update cycles, the query source is blocked for one slot so the update can win.
- Read data is broadcast to both requesters with registered per-requester return-valid strobes.

## Interface
Parameters:
- STARVE_N, default 8: consecutive denied update-request cycles before the query source is blocked; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- i_qry_ren  in  1  query pipeline read request; never stalled.
- i_qry_raddr  in  v_pkg::addr_t  query read address.
- o_qry_block  out  1  registered; the query source must not assert i_qry_ren while this is high.
- o_qry_rdata_vld  out  1  i_state_rdata belongs to the query issued last cycle.
- i_upd_req  in  1  update pipeline read request; held with address stable until granted.
- i_upd_raddr  in  v_pkg::addr_t  update read address.
- o_upd_gnt  out  1  combinational grant; request consumed this cycle.
- o_upd_rdata_vld  out  1  i_state_rdata belongs to the update granted last cycle.
- o_state_ren  out  1  RAM read enable.
- o_state_raddr  out  v_pkg::addr_t  RAM read address.
- o_err_proto  out  1  registered pulse: i_qry_ren asserted while o_qry_block=1.

## Operation
- Normal priority, o_qry_block=0:
  - i_qry_ren=1: o_state_ren=1, o_state_raddr=i_qry_raddr, o_upd_gnt=0.
  - i_qry_ren=0 and i_upd_req=1: o_state_ren=1, o_state_raddr=i_upd_raddr, o_upd_gnt=1.
  - Neither asserted: o_state_ren=0. o_state_raddr=i_qry_raddr (don't-care).
- Starve counter, width $clog2(STARVE_N+1):
  - Increments, saturating at STARVE_N, on each cycle with i_upd_req=1 and o_upd_gnt=0.
  - Clears on a cycle with o_upd_gnt=1, or a cycle with i_upd_req=0.
- Block flag, o_qry_block:
  - Sets at the next edge when the counter equals STARVE_N-1 and the update is denied again, i.e. on the STARVE_N-th denied cycle.
  - While set, the update has priority: o_upd_gnt=i_upd_req.
  - Clears at the edge following a grant, or when i_upd_req=0, whichever comes first.
- Protocol violation (i_qry_ren=1 while o_qry_block=1):
  - The query still wins, because the latency path is never broken.
  - The update is denied that cycle.
  - o_err_proto pulses the next cycle.
  - The block flag stays set.
- Update abandonment: i_upd_req dropping before grant is legal only during rst. Otherwise it is out of contract, but the counter and flag must still clear as specified.

## Timing
- Arbitration and RAM command: combinational, same cycle.
- Read data: i_state_rdata valid exactly one cycle after o_state_ren.
- Return strobes, registered:
  - o_qry_rdata_vld(t+1) = query granted at t.
  - o_upd_rdata_vld(t+1) = o_upd_gnt at t.
  - Never both high in the same cycle.
- Reset values, all registers synchronous on rst:
  - o_qry_block=0, o_qry_rdata_vld=0, o_upd_rdata_vld=0, o_err_proto=0, counter=0.
  - Combinational outputs follow the inputs during rst. o_upd_gnt is forced 0 while rst=1.
- Reset mid-operation: strobes for requests issued in the reset cycle are suppressed. The block flag drops the cycle after rst is asserted.
- Worst-case update grant latency with the feature enabled, given a compliant query source: STARVE_N+1 cycles after i_upd_req rises.

## Configuration
- Macro: V_STATE_RD_ARB_STARVE_EN.
- Defined:
  - Starve counter, o_qry_block and o_err_proto are implemented as described above.
- Undefined:
  - Strict query priority; updates can starve indefinitely.
  - o_qry_block and o_err_proto are tied 0.
  - No counter flops; STARVE_N is ignored.

## Test plan
- Idle, then i_upd_req=1 with addr 0x05 and no query -> o_upd_gnt=1 same cycle, o_state_raddr=0x05, o_upd_rdata_vld=1 next cycle.
- Query at 0x03 and update at 0x07 requested together -> query wins: raddr=0x03, o_upd_gnt=0, o_qry_rdata_vld=1 next cycle. Update is granted on the first query-free cycle.
- STARVE_EN, STARVE_N=4, query every cycle, update held -> o_qry_block=1 after the 4th denied cycle. With the source compliant, o_upd_gnt=1 in the block cycle, then o_qry_block=0.
- Same as above but the source ignores o_qry_block -> query still granted, o_err_proto=1 next cycle, o_qry_block stays 1 until the update is granted.
- rst asserted one cycle after a query grant -> o_qry_rdata_vld=0, o_qry_block=0, counter=0. After release, an update is granted on the first free cycle.
- STARVE_EN undefined, 20 cycles of back-to-back queries with an update held -> o_upd_gnt=0 throughout, o_qry_block=0, o_err_proto=0.
